// File: rtl/uart_pkg.sv
// Shared serial-link definitions used by both ends of the UART link.
package uart_pkg;

    localparam int UART_BIT_CYCLES = 8;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous holding FIFO with first-word fall-through head; push while full
// and pop while empty are ignored.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests against the registered occupancy.
    always_comb begin
        push_ok_s = push && (count_r != DEPTH_C);
        pop_ok_s  = pop && (count_r != '0);
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage write; a reset edge never latches data.
    always_ff @(posedge clk) begin
        if (!reset && push_ok_s) mem_r[wr_ptr_r] <= wdata;
    end

    assign head  = mem_r[rd_ptr_r];
    assign full  = (count_r == DEPTH_C);
    assign empty = (count_r == '0);
    assign count = count_r;

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: buffers words in a small FIFO and serialises them as
// start bit, eight data bits LSB first, and STOP_BITS stop bits.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int BIT_CYCLES = UART_BIT_CYCLES,
    parameter int STOP_BITS  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        gl_reset,
    input  logic [UART_DATA_BITS-1:0]   dIn,
    input  logic                        dValid,
    output logic                        dAccept,
    output logic                        dOut,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifoCount
);

    localparam int CNT_W = $clog2(BIT_CYCLES * STOP_BITS);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(BIT_CYCLES * STOP_BITS - 1);
    localparam logic [2:0]       BIT_MAX   = 3'(UART_DATA_BITS - 1);

    tx_state_t                 state_r, state_next_s;
    logic [CNT_W-1:0]          cycle_r, cycle_next_s;
    logic [2:0]                bit_r, bit_next_s;
    logic [UART_DATA_BITS-1:0] shift_r, shift_next_s;
    logic                      dout_r, dout_s;
    logic                      busy_r;
    logic                      push_s, pop_s;
    logic                      full_s, empty_s;
    logic [UART_DATA_BITS-1:0] head_s;

    uart_tx_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (gl_reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (dIn),
        .head  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (fifoCount)
    );

    // dOut follows the state one clock later, so it is low from the second edge after a push.
    always_ff @(posedge clk) begin
        if (gl_reset) begin
            state_r <= IDLE;
            cycle_r <= '0;
            bit_r   <= '0;
            shift_r <= '0;
            dout_r  <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cycle_r <= cycle_next_s;
            bit_r   <= bit_next_s;
            shift_r <= shift_next_s;
            dout_r  <= dout_s;
            busy_r  <= (state_next_s != IDLE);
        end
    end

    // Next-state, counter and shift-register update.
    always_comb begin
        state_next_s = state_r;
        cycle_next_s = cycle_r;
        bit_next_s   = bit_r;
        shift_next_s = shift_r;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    shift_next_s = head_s;
                    cycle_next_s = '0;
                    bit_next_s   = '0;
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (cycle_r == BIT_LAST) begin
                    cycle_next_s = '0;
                    state_next_s = DATA;
                end else begin
                    cycle_next_s = cycle_r + CNT_W'(1);
                end
            end
            DATA: begin
                if (cycle_r == BIT_LAST) begin
                    cycle_next_s = '0;
                    shift_next_s = {1'b0, shift_r[UART_DATA_BITS-1:1]};
                    if (bit_r == BIT_MAX) begin
                        bit_next_s   = '0;
                        state_next_s = STOP;
                    end else begin
                        bit_next_s = bit_r + 3'd1;
                    end
                end else begin
                    cycle_next_s = cycle_r + CNT_W'(1);
                end
            end
            STOP: begin
                if (cycle_r == STOP_LAST) begin
                    cycle_next_s = '0;
                    state_next_s = IDLE;
                end else begin
                    cycle_next_s = cycle_r + CNT_W'(1);
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Line level, FIFO pop and handshake decode.
    always_comb begin
        pop_s   = (state_r == IDLE) && !empty_s;
        push_s  = dValid && !full_s;
        dAccept = !full_s;
        case (state_r)
            IDLE:    dout_s = 1'b1;
            START:   dout_s = 1'b0;
            DATA:    dout_s = shift_r[0];
            STOP:    dout_s = 1'b1;
            default: dout_s = 1'b1;
        endcase
    end

    assign dOut = dout_r;
    assign busy = busy_r;

endmodule
